// File: rtl/prim_pad_bank_ctrl.sv
// rtl/prim_pad_bank_ctrl.sv - bank of pad channels with registered drive, pulls, filtered input and edge flags
module prim_pad_bank_ctrl #(
  parameter int NPads      = 8,
  parameter int AttrDw     = 7,
  parameter int FiltCycles = 4,
  localparam int IdxW      = (NPads > 1) ? $clog2(NPads) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NPads-1:0]          out_i,
  input  logic [NPads-1:0]          oe_i,
  output logic [NPads-1:0]          in_o,
  input  logic                      attr_we_i,
  input  logic [IdxW-1:0]           attr_idx_i,
  input  logic [AttrDw-1:0]         attr_wdata_i,
  output logic [NPads*AttrDw-1:0]   attr_o,
  input  logic [NPads-1:0]          evt_clr_i,
  output logic [NPads-1:0]          rise_o,
  output logic [NPads-1:0]          fall_o,
  input  logic [NPads-1:0]          pad_in_i,
  output logic [NPads-1:0]          pad_out_o,
  output logic [NPads-1:0]          pad_oe_o,
  output logic [NPads-1:0]          pad_drv_o,
  output logic [NPads-1:0]          pad_pu_o,
  output logic [NPads-1:0]          pad_pd_o
);

  localparam int CntW = $clog2(FiltCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FiltCycles - 1);

  logic [AttrDw-1:0] attr_q [NPads];
  logic [CntW-1:0]   cnt_q  [NPads];
  logic [NPads-1:0]  sync1_q, sync2_q, filt_q, prev_q, rise_q, fall_q;
  logic [NPads-1:0]  pad_out_q, pad_oe_q, pad_pu_q, pad_pd_q;
  logic [NPads-1:0]  inv, od, pd, pu, kp, drv, filt_en;
  logic [NPads-1:0]  out_d, oe_d, pu_eff, pd_eff, in_d;

  always_comb begin
    attr_o  = '0;
    inv     = '0;
    od      = '0;
    pd      = '0;
    pu      = '0;
    kp      = '0;
    drv     = '0;
    filt_en = '0;
    for (int n = 0; n < NPads; n++) begin
      inv[n]     = attr_q[n][0];
      od[n]      = attr_q[n][1];
      pd[n]      = attr_q[n][2];
      pu[n]      = attr_q[n][3];
      kp[n]      = attr_q[n][4];
      drv[n]     = attr_q[n][5];
      filt_en[n] = attr_q[n][6];
      attr_o[n*AttrDw +: AttrDw] = attr_q[n];
    end
  end

  // Open-drain channels only ever drive low; a high output releases the pad.
  assign out_d  = out_i ^ inv;
  assign oe_d   = oe_i & (~od | ~out_d);
  assign pu_eff = pu | (kp & ~oe_d & filt_q);
  assign pd_eff = pd | (kp & ~oe_d & ~filt_q);
  assign in_d   = filt_q ^ inv;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NPads; n++) begin
        attr_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      prev_q    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pad_out_q <= '0;
      pad_oe_q  <= '0;
      pad_pu_q  <= '0;
      pad_pd_q  <= '0;
    end else begin
      for (int n = 0; n < NPads; n++) begin
        if (attr_we_i && attr_idx_i == IdxW'(n)) begin
          attr_q[n] <= attr_wdata_i;
        end
        // The filter commits only after FiltCycles consecutive disagreeing samples.
        if (!filt_en[n]) begin
          filt_q[n] <= sync2_q[n];
          cnt_q[n]  <= '0;
        end else if (sync2_q[n] == filt_q[n]) begin
          cnt_q[n] <= '0;
        end else if (cnt_q[n] == CntMax) begin
          filt_q[n] <= sync2_q[n];
          cnt_q[n]  <= '0;
        end else begin
          cnt_q[n] <= cnt_q[n] + CntW'(1);
        end
      end
      sync1_q   <= pad_in_i;
      sync2_q   <= sync1_q;
      pad_out_q <= out_d;
      pad_oe_q  <= oe_d;
      pad_pu_q  <= pu_eff & ~pd_eff;
      pad_pd_q  <= pd_eff & ~pu_eff;
      prev_q    <= in_d;
      // A new edge beats a simultaneous clear.
      rise_q    <= (rise_q & ~evt_clr_i) | (in_d & ~prev_q);
      fall_q    <= (fall_q & ~evt_clr_i) | (~in_d & prev_q);
    end
  end

  assign in_o      = in_d;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pad_out_o = pad_out_q;
  assign pad_oe_o  = pad_oe_q;
  assign pad_drv_o = drv;
  assign pad_pu_o  = pad_pu_q;
  assign pad_pd_o  = pad_pd_q;

endmodule

// File: tb/tb_prim_pad_bank_ctrl.sv
// tb/tb_prim_pad_bank_ctrl.sv - self-checking bench for prim_pad_bank_ctrl
module tb_prim_pad_bank_ctrl;
  localparam int NP = 6;
  localparam int AW = 8;
  localparam int FC = 4;
  localparam int IW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NP-1:0]  out = '0, oe = '0, pad_in = '0, clr = '0;
  logic           we = 1'b0;
  logic [IW-1:0]  idx = '0;
  logic [AW-1:0]  wdata = '0;
  logic [NP-1:0]  in_v, rise, fall, pad_out, pad_oe, pad_drv, pad_pu, pad_pd;
  logic [NP*AW-1:0] attr_v;

  int total = 0;
  int bad   = 0;

  prim_pad_bank_ctrl #(.NPads(NP), .AttrDw(AW), .FiltCycles(FC)) dut (
    .clk_i(clk), .rst_i(rst), .out_i(out), .oe_i(oe), .in_o(in_v),
    .attr_we_i(we), .attr_idx_i(idx), .attr_wdata_i(wdata), .attr_o(attr_v),
    .evt_clr_i(clr), .rise_o(rise), .fall_o(fall), .pad_in_i(pad_in),
    .pad_out_o(pad_out), .pad_oe_o(pad_oe), .pad_drv_o(pad_drv),
    .pad_pu_o(pad_pu), .pad_pd_o(pad_pd)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel state advanced once per rising edge from the spec rules.
  logic [AW-1:0] m_attr [NP] = '{default: '0};
  logic [NP-1:0] m_s1 = '0, m_s2 = '0, m_f = '0, m_p = '0, m_rise = '0, m_fall = '0;
  logic [NP-1:0] m_pout = '0, m_poe = '0, m_pu = '0, m_pd = '0;
  int            m_run [NP] = '{default: 0};

  function automatic logic [NP-1:0] m_bit(input int b);
    logic [NP-1:0] r;
    for (int n = 0; n < NP; n++) r[n] = m_attr[n][b];
    return r;
  endfunction

  function automatic logic [NP*AW-1:0] m_attr_flat();
    logic [NP*AW-1:0] r;
    for (int n = 0; n < NP; n++) r[n*AW +: AW] = m_attr[n];
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [NP-1:0] inv, o, e, pue, pde, cur_in, nf;
    if (rst) begin
      for (int n = 0; n < NP; n++) begin
        m_attr[n] = '0;
        m_run[n]  = 0;
      end
      {m_s1, m_s2, m_f, m_p, m_rise, m_fall} = '0;
      {m_pout, m_poe, m_pu, m_pd} = '0;
    end else begin
      inv    = m_bit(0);
      o      = out ^ inv;
      e      = oe & ~(m_bit(1) & o);
      pue    = m_bit(3) | (m_bit(4) & ~e & m_f);
      pde    = m_bit(2) | (m_bit(4) & ~e & ~m_f);
      m_pout = o;
      m_poe  = e;
      m_pu   = pue & ~pde;
      m_pd   = pde & ~pue;
      cur_in = m_f ^ inv;
      m_rise = (m_rise & ~clr) | (cur_in & ~m_p);
      m_fall = (m_fall & ~clr) | (~cur_in & m_p);
      m_p    = cur_in;
      nf     = m_f;
      for (int n = 0; n < NP; n++) begin
        if (!m_attr[n][6]) begin
          nf[n]    = m_s2[n];
          m_run[n] = 0;
        end else if (m_s2[n] == m_f[n]) begin
          m_run[n] = 0;
        end else begin
          m_run[n] = m_run[n] + 1;
          if (m_run[n] == FC) begin
            nf[n]    = m_s2[n];
            m_run[n] = 0;
          end
        end
      end
      m_f  = nf;
      m_s2 = m_s1;
      m_s1 = pad_in;
      if (we && int'(idx) < NP) m_attr[idx] = wdata;
    end
  end

  task automatic wr(input int i, input logic [AW-1:0] d);
    we = 1'b1;
    idx = IW'(i);
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out = NP'($urandom); oe = NP'($urandom); pad_in = NP'($urandom); clr = NP'($urandom);
    we = 1'b1; idx = IW'($urandom_range(0, NP - 1)); wdata = AW'($urandom);
    repeat (2) @(negedge clk);
    total += 9;
    if (pad_out !== '0) begin bad++; $display("FAIL reset_pad_out: got %h want 0", pad_out); end
    if (pad_oe  !== '0) begin bad++; $display("FAIL reset_pad_oe: got %h want 0", pad_oe); end
    if (pad_pu  !== '0) begin bad++; $display("FAIL reset_pad_pu: got %h want 0", pad_pu); end
    if (pad_pd  !== '0) begin bad++; $display("FAIL reset_pad_pd: got %h want 0", pad_pd); end
    if (pad_drv !== '0) begin bad++; $display("FAIL reset_pad_drv: got %h want 0", pad_drv); end
    if (in_v    !== '0) begin bad++; $display("FAIL reset_in: got %h want 0", in_v); end
    if (attr_v  !== '0) begin bad++; $display("FAIL reset_attr: got %h want 0", attr_v); end
    if (rise    !== '0) begin bad++; $display("FAIL reset_rise: got %h want 0", rise); end
    if (fall    !== '0) begin bad++; $display("FAIL reset_fall: got %h want 0", fall); end
    out = '0; oe = '0; pad_in = '0; clr = '0; we = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_open_drain();
    logic [2:0] pat = 3'b101;
    logic [2:0] exp_oe = 3'b010;
    wr(0, 8'h02);
    oe[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      out[0] = pat[i];
      @(negedge clk);
      total += 2;
      if (pad_oe[0] !== exp_oe[i]) begin bad++; $display("FAIL od_oe[%0d]: got %b want %b", i, pad_oe[0], exp_oe[i]); end
      if (pad_out[0] !== pat[i]) begin bad++; $display("FAIL od_out[%0d]: got %b want %b", i, pad_out[0], pat[i]); end
    end
    oe[0] = 1'b0;
    out[0] = 1'b0;
  endtask

  task automatic test_glitch_filter();
    wr(1, 8'h40);
    repeat (2) @(negedge clk);
    pad_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    pad_in[1] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (in_v[1] !== 1'b0) begin bad++; $display("FAIL glitch_short_in[%0d]: got %b want 0", i, in_v[1]); end
    end
    total++;
    if (rise[1] !== 1'b0) begin bad++; $display("FAIL glitch_short_rise: got %b want 0", rise[1]); end
    pad_in[1] = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      total++;
      if (in_v[1] !== 1'(i >= 6 && i <= 9))
        begin bad++; $display("FAIL glitch_long_in[%0d]: got %b want %b", i, in_v[1], (i >= 6 && i <= 9)); end
      if (i == 6) begin
        total++;
        if (rise[1] !== 1'b0) begin bad++; $display("FAIL glitch_rise_early: got %b want 0", rise[1]); end
      end
      if (i == 7) begin
        total++;
        if (rise[1] !== 1'b1) begin bad++; $display("FAIL glitch_rise: got %b want 1", rise[1]); end
      end
      if (i == 11) begin
        total++;
        if (fall[1] !== 1'b1) begin bad++; $display("FAIL glitch_fall: got %b want 1", fall[1]); end
      end
      if (i == 4) pad_in[1] = 1'b0;
    end
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    total++;
    if ({rise[1], fall[1]} !== 2'b00) begin bad++; $display("FAIL glitch_clear: got %b want 00", {rise[1], fall[1]}); end
  endtask

  task automatic test_keeper();
    wr(2, 8'h10);
    oe[2] = 1'b0;
    repeat (5) @(negedge clk);
    total += 2;
    if (pad_pd[2] !== 1'b1) begin bad++; $display("FAIL keeper_low_pd: got %b want 1", pad_pd[2]); end
    if (pad_pu[2] !== 1'b0) begin bad++; $display("FAIL keeper_low_pu: got %b want 0", pad_pu[2]); end
    pad_in[2] = 1'b1;
    repeat (5) @(negedge clk);
    total += 2;
    if (pad_pu[2] !== 1'b1) begin bad++; $display("FAIL keeper_high_pu: got %b want 1", pad_pu[2]); end
    if (pad_pd[2] !== 1'b0) begin bad++; $display("FAIL keeper_high_pd: got %b want 0", pad_pd[2]); end
    oe[2] = 1'b1;
    @(negedge clk);
    total++;
    if ({pad_pu[2], pad_pd[2]} !== 2'b00) begin bad++; $display("FAIL keeper_driving: got %b want 00", {pad_pu[2], pad_pd[2]}); end
    oe[2] = 1'b0;
    pad_in[2] = 1'b0;
  endtask

  task automatic test_conflict_inv();
    wr(3, 8'h0D);
    total++;
    if (in_v[3] !== 1'b1) begin bad++; $display("FAIL inv_immediate: got %b want 1", in_v[3]); end
    repeat (3) @(negedge clk);
    total++;
    if ({pad_pu[3], pad_pd[3]} !== 2'b00) begin bad++; $display("FAIL pull_conflict: got %b want 00", {pad_pu[3], pad_pd[3]}); end
    pad_in[3] = 1'b1;
    repeat (4) @(negedge clk);
    total += 2;
    if (in_v[3] !== 1'b0) begin bad++; $display("FAIL inv_high: got %b want 0", in_v[3]); end
    if ({pad_pu[3], pad_pd[3]} !== 2'b00) begin bad++; $display("FAIL pull_conflict_high: got %b want 00", {pad_pu[3], pad_pd[3]}); end
  endtask

  task automatic test_evt_race();
    pad_in[4] = 1'b1;
    repeat (3) @(negedge clk);
    total += 2;
    if (in_v[4] !== 1'b1) begin bad++; $display("FAIL race_in: got %b want 1", in_v[4]); end
    if (rise[4] !== 1'b0) begin bad++; $display("FAIL race_pre_rise: got %b want 0", rise[4]); end
    clr[4] = 1'b1;
    @(negedge clk);
    total++;
    if (rise[4] !== 1'b1) begin bad++; $display("FAIL race_set_wins: got %b want 1", rise[4]); end
    @(negedge clk);
    clr[4] = 1'b0;
    total++;
    if (rise[4] !== 1'b0) begin bad++; $display("FAIL race_cleared: got %b want 0", rise[4]); end
  endtask

  task automatic test_bad_index();
    logic [NP*AW-1:0] exp_attr = {8'hA0, 8'h00, 8'h0D, 8'h10, 8'h40, 8'h02};
    wr(5, 8'hA0);
    total++;
    if (pad_drv[5] !== 1'b1) begin bad++; $display("FAIL drv_weak: got %b want 1", pad_drv[5]); end
    wr(6, 8'h7F);
    wr(7, 8'h55);
    total++;
    if (attr_v !== exp_attr) begin bad++; $display("FAIL bad_index_attr: got %h want %h", attr_v, exp_attr); end
  endtask

  task automatic test_random();
    int k;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      total += 9;
      if (in_v    !== (m_f ^ m_bit(0))) begin bad++; $display("FAIL rnd_in@%0d: got %h want %h", c, in_v, m_f ^ m_bit(0)); end
      if (attr_v  !== m_attr_flat()) begin bad++; $display("FAIL rnd_attr@%0d: got %h want %h", c, attr_v, m_attr_flat()); end
      if (rise    !== m_rise) begin bad++; $display("FAIL rnd_rise@%0d: got %h want %h", c, rise, m_rise); end
      if (fall    !== m_fall) begin bad++; $display("FAIL rnd_fall@%0d: got %h want %h", c, fall, m_fall); end
      if (pad_out !== m_pout) begin bad++; $display("FAIL rnd_pad_out@%0d: got %h want %h", c, pad_out, m_pout); end
      if (pad_oe  !== m_poe) begin bad++; $display("FAIL rnd_pad_oe@%0d: got %h want %h", c, pad_oe, m_poe); end
      if (pad_drv !== m_bit(5)) begin bad++; $display("FAIL rnd_pad_drv@%0d: got %h want %h", c, pad_drv, m_bit(5)); end
      if (pad_pu  !== m_pu) begin bad++; $display("FAIL rnd_pad_pu@%0d: got %h want %h", c, pad_pu, m_pu); end
      if (pad_pd  !== m_pd) begin bad++; $display("FAIL rnd_pad_pd@%0d: got %h want %h", c, pad_pd, m_pd); end
      rst = ($urandom_range(0, 199) == 0);
      out = NP'($urandom);
      oe  = NP'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, NP - 1);
        pad_in[k] = ~pad_in[k];
      end
      clr   = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
      we    = ($urandom_range(0, 9) == 0);
      idx   = IW'($urandom_range(0, 7));
      wdata = AW'($urandom);
    end
    rst = 1'b0;
    we  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_open_drain();
    test_glitch_filter();
    test_keeper();
    test_conflict_inv();
    test_evt_race();
    test_bad_index();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
